// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM among NUM_CH requesters.
// Fixed priority by default; define ROUND_ROBIN_EN for round-robin arbitration.
module ram_port_arbiter #(
   parameter int NUM_CH        = 2,
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 16,
   parameter int RAM_LATENCY   = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_CH-1:0]               i_req,
   input  logic [NUM_CH-1:0]               i_we,
   input  logic [NUM_CH*ADDRESS_WIDTH-1:0] i_addr,
   input  logic [NUM_CH*DATA_WIDTH-1:0]    i_wdata,
   output logic [NUM_CH-1:0]               o_gnt,
   output logic [DATA_WIDTH-1:0]           o_rdata,
   output logic [NUM_CH-1:0]               o_rvalid,
   output logic                            o_ram_ce,
   output logic                            o_ram_we,
   output logic [ADDRESS_WIDTH-1:0]        o_ram_addr,
   output logic [DATA_WIDTH-1:0]           o_ram_wdata,
   input  logic [DATA_WIDTH-1:0]           i_ram_rdata,
   output logic                            o_busy
);
   localparam int CH_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0]        w_gnt;
   logic [CH_W-1:0]          w_idx;
   logic                     w_xfer;
   logic                     w_rd;
   int                       w_start;

   logic                     r_ce;
   logic                     r_we;
   logic [ADDRESS_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0]    r_wdata;
   logic [DATA_WIDTH-1:0]    r_rdata;
   logic [NUM_CH-1:0]        r_rvalid;
   logic [RAM_LATENCY:0]     r_rd_pipe;
   logic [RAM_LATENCY:0][CH_W-1:0] r_ch_pipe;

`ifdef ROUND_ROBIN_EN
   logic [CH_W-1:0] r_ptr;

   // Pointer remembers the last winner; search resumes just past it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_ptr <= CH_W'(NUM_CH-1);
      else if (w_xfer) r_ptr <= w_idx;
   end

   assign w_start = (int'(r_ptr) == NUM_CH-1) ? 0 : int'(r_ptr) + 1;
`else
   assign w_start = 0;
`endif

   always_comb begin
      w_gnt  = '0;
      w_idx  = '0;
      w_xfer = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!w_xfer && i_req[(w_start + k) % NUM_CH]) begin
            w_xfer = 1'b1;
            w_idx  = CH_W'((w_start + k) % NUM_CH);
         end
      end
      if (w_xfer) w_gnt[w_idx] = 1'b1;
   end

   assign w_rd = w_xfer & ~i_we[w_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ce    <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_ce <= w_xfer;
         r_we <= w_xfer & i_we[w_idx];
         if (w_xfer) begin
            r_addr  <= i_addr[w_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            r_wdata <= i_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Tag stage k tracks the access issued k+1 edges ago; the last stage lines up with ram_rdata.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_pipe <= '0;
         r_ch_pipe <= '0;
         r_rdata   <= '0;
         r_rvalid  <= '0;
      end else begin
         r_rd_pipe[0] <= w_rd;
         r_ch_pipe[0] <= w_idx;
         for (int s = 1; s <= RAM_LATENCY; s++) begin
            r_rd_pipe[s] <= r_rd_pipe[s-1];
            r_ch_pipe[s] <= r_ch_pipe[s-1];
         end
         r_rvalid <= '0;
         if (r_rd_pipe[RAM_LATENCY]) begin
            r_rdata                               <= i_ram_rdata;
            r_rvalid[r_ch_pipe[RAM_LATENCY]]      <= 1'b1;
         end
      end
   end

   assign o_gnt       = w_gnt;
   assign o_rdata     = r_rdata;
   assign o_rvalid    = r_rvalid;
   assign o_ram_ce    = r_ce;
   assign o_ram_we    = r_we;
   assign o_ram_addr  = r_addr;
   assign o_ram_wdata = r_wdata;
   assign o_busy      = r_ce | (|r_rd_pipe);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter: 4 channels, RAM latency 3, behavioural RAM,
// transaction-level reference model with an in-order read scoreboard.
module tb_ram_port_arbiter;
   localparam int NC  = 4;
   localparam int DW  = 8;
   localparam int AW  = 16;
   localparam int LAT = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NC-1:0]    req, we, gnt, rvalid;
   logic [NC*AW-1:0] addr;
   logic [NC*DW-1:0] wdata;
   logic [DW-1:0]    rdata, ram_wdata, ram_rdata;
   logic [AW-1:0]    ram_addr;
   logic             ram_ce, ram_we, busy;

   always #5 clk = ~clk;

   ram_port_arbiter #(.NUM_CH(NC), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .RAM_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
      .o_gnt(gnt), .o_rdata(rdata), .o_rvalid(rvalid), .o_ram_ce(ram_ce), .o_ram_we(ram_we),
      .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata), .o_busy(busy));

   // Synchronous RAM: command sampled at an edge, data valid LAT-1 edges later.
   logic [DW-1:0] ram_mem  [32];
   logic [DW-1:0] ram_line [LAT];
   always @(posedge clk) begin
      if (ram_ce && ram_we) ram_mem[ram_addr[4:0]] <= ram_wdata;
      ram_line[0] <= ram_mem[ram_addr[4:0]];
      for (int i = 1; i < LAT; i++) ram_line[i] <= ram_line[i-1];
   end
   assign ram_rdata = ram_line[LAT-1];

   typedef struct { int ch; logic [DW-1:0] d; int due; } rd_t;

   int            n_chk = 0, n_err = 0;
   logic [NC-1:0] p_req = '0, p_we = '0;
   logic [AW-1:0] p_addr  [NC];
   logic [DW-1:0] p_wdata [NC];
   logic [DW-1:0] shadow  [32];
   rd_t           q[$];
   int            m_ptr = NC-1, ne = 0;
   logic          exp_ce = 0, exp_we = 0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_wdata = '0, exp_rdata = '0;

   task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, ne);
      end
   endtask

   function automatic int pick();
      int s = 0;
`ifdef ROUND_ROBIN_EN
      s = (m_ptr + 1) % NC;
`endif
      for (int k = 0; k < NC; k++)
         if (p_req[(s + k) % NC]) return (s + k) % NC;
      return -1;
   endfunction

   task automatic model_reset();
      q.delete();
      m_ptr = NC-1; exp_ce = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
      p_req = '0;
   endtask

   // One clock: drive pending requests, check grant, advance model, check registered outputs.
   task automatic cycle();
      int g;
      logic [NC-1:0] eg, erv;
      for (int c = 0; c < NC; c++) begin
         req[c] = p_req[c];
         we[c]  = p_we[c];
         addr[c*AW +: AW]  = p_addr[c];
         wdata[c*DW +: DW] = p_wdata[c];
      end
      #1;
      g  = pick();
      eg = (g < 0) ? '0 : NC'(1) << g;
      chk("gnt", 32'(gnt), 32'(eg));
      @(posedge clk);
      ne++;
      if (g >= 0) begin
         exp_ce = 1; exp_we = p_we[g]; exp_addr = p_addr[g]; exp_wdata = p_wdata[g];
         if (p_we[g]) shadow[p_addr[g][4:0]] = p_wdata[g];
         else q.push_back('{g, shadow[p_addr[g][4:0]], ne + LAT + 1});
         m_ptr = g;
         p_req[g] = 1'b0;
      end else begin
         exp_ce = 0; exp_we = 0;
      end
      @(negedge clk);
      chk("ram_ce", 32'(ram_ce), 32'(exp_ce));
      chk("ram_we", 32'(ram_we), 32'(exp_we));
      chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
      chk("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
      erv = '0;
      if (q.size() > 0 && q[0].due == ne) begin
         erv = NC'(1) << q[0].ch;
         exp_rdata = q[0].d;
         void'(q.pop_front());
      end
      chk("rvalid", 32'(rvalid), 32'(erv));
      chk("rdata", 32'(rdata), 32'(exp_rdata));
      chk("busy", 32'(busy), 32'(exp_ce | (q.size() > 0)));
   endtask

   task automatic put(int c, logic w, int a, logic [DW-1:0] d);
      p_req[c] = 1'b1; p_we[c] = w; p_addr[c] = AW'(a); p_wdata[c] = d;
   endtask

   task automatic drain();
      int n = 0;
      while (|p_req && n < 40) begin cycle(); n++; end
      if (|p_req) begin
         chk("drain_timeout", 32'(p_req), 0);
         p_req = '0;
      end
   endtask

   task automatic idle(int n);
      p_req = '0;
      repeat (n) cycle();
   endtask

   task automatic rand_phase(int n, int pct_req, int pct_rd, int pct_drop);
      repeat (n) begin
         for (int c = 0; c < NC; c++) begin
            if (p_req[c]) begin
               if ($urandom_range(99) < pct_drop) p_req[c] = 1'b0;
            end else if ($urandom_range(99) < pct_req) begin
               put(c, $urandom_range(99) >= pct_rd, $urandom_range(15), DW'($urandom));
            end
         end
         cycle();
      end
   endtask

   initial begin
      for (int c = 0; c < NC; c++) begin p_addr[c] = '0; p_wdata[c] = '0; end
      for (int i = 0; i < 32; i++) shadow[i] = '0;
      rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_ce", 32'(ram_ce), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_addr", 32'(ram_addr), 0);
      req = 4'b0110; #1;
      chk("rst_gnt", 32'(gnt), 32'(4'b0010));
      req = '0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ce", 32'(ram_ce), 0);
      chk("rel_rdata", 32'(rdata), 0);

      for (int a = 0; a < 16; a += NC) begin
         for (int c = 0; c < NC; c++) put(c, 1'b1, a + c, DW'($urandom));
         drain();
      end
      put(1, 1'b1, 'h10, 8'hA5); drain();
      put(1, 1'b0, 'h10, 8'h00); drain();
      idle(LAT + 2);
      chk("a5_rdata", 32'(rdata), 32'h A5);

      for (int c = 0; c < NC; c++) put(c, 1'b1, c, DW'(8'h11 * (c + 1)));
      drain();
      for (int c = 0; c < NC; c++) put(c, 1'b0, c, '0);
      drain();
      idle(LAT + 2);

      rand_phase(40, 100, 100, 0);
      idle(LAT + 2);
      rand_phase(300, 40, 60, 8);
      rand_phase(200, 90, 50, 3);
      idle(LAT + 2);

      put(2, 1'b0, 5, '0);
      cycle();
      rst_n = 1'b0; #1;
      chk("mid_rst_ce", 32'(ram_ce), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_rvalid", 32'(rvalid), 0);
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      idle(LAT + 3);

      rand_phase(200, 60, 50, 5);
      idle(LAT + 3);
      chk("flush", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Parametrised N-channel arbiter that shares one single-port synchronous RAM among NUM_CH requesters through a valid/grant handshake. It replaces bidirectional data buses with separate write/read paths, registers the RAM command, and returns read data to the issuing channel with a per-channel valid strobe. Selectable fixed or round-robin priority. Sits between the decoder stages (Huffman tables, coefficient buffers, pixel output) and each shared block RAM.

## Interface
- NUM_CH, 2, number of requesting channels (2..8)
- DATA_WIDTH, 8, RAM word width
- ADDRESS_WIDTH, 16, RAM address width
- RAM_LATENCY, 1, RAM read latency in cycles from command-sampling edge to valid ram_rdata (1..4)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_CH  per-channel request valid
- we  in  NUM_CH  per-channel write enable (1 = write, 0 = read)
- addr  in  NUM_CH*ADDRESS_WIDTH  channel i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- wdata  in  NUM_CH*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- gnt  out  NUM_CH  one-hot (or zero) combinational grant
- rdata  out  DATA_WIDTH  registered read data, shared by all channels
- rvalid  out  NUM_CH  one-cycle strobe, rdata belongs to channel i
- ram_ce  out  1  registered RAM chip enable
- ram_we  out  1  registered RAM write enable
- ram_addr  out  ADDRESS_WIDTH  registered RAM address
- ram_wdata  out  DATA_WIDTH  registered RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data
- busy  out  1  ram_ce or any read in flight

## Operation
- Transfer on channel i at a rising edge when req[i] && gnt[i]. At most one transfer per cycle.
- gnt is a function of req and the priority pointer only; at most one bit set; gnt[i] never set without req[i].
- Requester holds req, we, addr, wdata stable until transfer; may present the next request in the following cycle (back-to-back, one access per cycle).
- On transfer: ram_ce=1, ram_we=we[i], ram_addr/ram_wdata loaded from channel i. No transfer: ram_ce=0, ram_we=0; addr/wdata hold.
- Read tag pipeline: RAM_LATENCY+1 stages of {is_read, channel index}; shifted every cycle, entered on every edge (is_read=0 when no read transfer).
- At pipeline exit with is_read=1: rdata <= ram_rdata, rvalid[ch] <= 1 for one cycle. Otherwise rvalid <= 0, rdata holds.
- Writes produce no rvalid.
- Fixed priority (default): lowest asserted req index wins.
- busy = ram_ce | any is_read in tag pipeline.

## Timing
- Reset values: gnt follows req (combinational, pointer reset); rdata=0, rvalid=0, ram_ce=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0; tag pipeline cleared; round-robin pointer = NUM_CH-1.
- Command latency: transfer at edge t -> RAM command visible cycle t..t+1.
- Read latency: rvalid high in the cycle after edge t+RAM_LATENCY+1 (RAM_LATENCY=1: two edges after transfer).
- Full throughput: one read per cycle sustained; rvalid stream in same order as transfers.
- Simultaneous requests: exactly one granted per cycle; losers keep req and see gnt later.
- Channel deasserts req before grant: no access issued, no error.
- Reset mid-operation: in-flight reads dropped, no rvalid after reset release; RAM command cleared asynchronously.

## Configuration
- ROUND_ROBIN_EN defined: pointer holds last transferred channel; search starts at pointer+1 modulo NUM_CH; pointer updates only on transfer. Every continuously requesting channel is granted within NUM_CH transfers.
- ROUND_ROBIN_EN undefined: fixed priority, channel 0 highest; no pointer register.

## Test plan
- Reset, NUM_CH=2, RAM_LATENCY=1: no req -> all outputs 0, busy=0; release rst_n -> unchanged.
- Ch1 write addr 0x0010 data 0xA5, then ch1 read 0x0010 -> ram_we=1 one cycle; rdata=0xA5 with rvalid=2'b10 two edges after read transfer.
- Both channels read continuously, fixed priority -> gnt=2'b01 every cycle, ch1 starved; with ROUND_ROBIN_EN -> gnt alternates 01,10,01,..., rvalid alternates in same order.
- NUM_CH=4, RAM_LATENCY=3, back-to-back reads ch0..ch3 addrs 0..3 preloaded 0x11..0x44 -> rvalid 0001,0010,0100,1000 on consecutive cycles, 4 edges after each transfer, rdata 0x11..0x44.
- Read in flight, rst_n pulsed low -> rvalid stays 0, ram_ce=0, busy=0 immediately.
- Req dropped before gnt (lower channel active) -> no RAM access for dropped channel, no rvalid.
